// File: rtl/hu_pipeline_skid_if.sv
// Valid/ready stream bundle for hu_pipeline_skid: producer side (d*) and consumer side (q*).
// master = the environment driving d/d_valid/q_ready; slave = the pipeline block.
interface hu_pipeline_skid_if #(
    parameter type regtype = bit [7:0]
) ();
    regtype d;
    logic   d_valid;
    logic   d_ready;
    regtype q;
    logic   q_valid;
    logic   q_ready;

    modport master (
        output d, d_valid, q_ready,
        input  d_ready, q, q_valid
    );

    modport slave (
        input  d, d_valid, q_ready,
        output d_ready, q, q_valid
    );
endinterface

// File: rtl/hu_pipeline_skid.sv
// Elastic pipeline of `depth` skid-buffer stages; ready is registered per stage so q_ready never reaches d_ready.
// Optional occupancy output `count` enabled by defining HU_PIPELINE_SKID_COUNT_EN.
module hu_pipeline_skid #(
    parameter int unsigned depth = 1,
    parameter type regtype = bit [7:0],
    localparam int unsigned count_w = (depth == 0) ? 1 : $clog2(2 * depth + 1)
) (
    input logic clk,
    input logic rst_n,
    input logic clear,
    hu_pipeline_skid_if.slave bus
`ifdef HU_PIPELINE_SKID_COUNT_EN
    ,
    output logic [count_w-1:0] count
`endif
);

    if (depth == 0) begin : g_pass
        // Zero-depth build: pure wires, no state.
        logic unused;
        assign unused      = ^{clk, rst_n, clear};
        assign bus.q       = bus.d;
        assign bus.q_valid = bus.d_valid;
        assign bus.d_ready = bus.q_ready;
`ifdef HU_PIPELINE_SKID_COUNT_EN
        assign count = '0;
`endif
    end else begin : g_pipe
        regtype             main_d [depth];
        regtype             in_d   [depth];
        logic [depth-1:0]   main_v;
        logic [depth-1:0]   skid_v;
        logic [depth-1:0]   in_v;
        logic [depth-1:0]   out_rdy;

        for (genvar k = 0; k < depth; k++) begin : g_stage
            regtype main_q;
            regtype skid_q;
            logic   main_vq;
            logic   skid_vq;

            if (k == 0) begin : g_head
                assign in_d[0] = bus.d;
                assign in_v[0] = bus.d_valid;
            end else begin : g_link
                assign in_d[k]      = main_d[k-1];
                assign in_v[k]      = main_v[k-1];
                assign out_rdy[k-1] = !skid_v[k];
            end

            // Main drains (or refills from skid) whenever downstream takes it or it is empty;
            // otherwise a word offered while our ready was high lands in the skid.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_q  <= '0;
                    skid_q  <= '0;
                    main_vq <= 1'b0;
                    skid_vq <= 1'b0;
                end else if (clear) begin
                    main_vq <= 1'b0;
                    skid_vq <= 1'b0;
                end else if (out_rdy[k] || !main_vq) begin
                    main_q  <= skid_vq ? skid_q : in_d[k];
                    main_vq <= skid_vq || in_v[k];
                    skid_vq <= 1'b0;
                end else if (in_v[k] && !skid_vq) begin
                    skid_q  <= in_d[k];
                    skid_vq <= 1'b1;
                end
            end

            assign main_d[k] = main_q;
            assign main_v[k] = main_vq;
            assign skid_v[k] = skid_vq;
        end

        assign out_rdy[depth-1] = bus.q_ready;
        assign bus.q            = main_d[depth-1];
        assign bus.q_valid      = main_v[depth-1];
        assign bus.d_ready      = !skid_v[0];

`ifdef HU_PIPELINE_SKID_COUNT_EN
        logic in_fire;
        logic out_fire;
        assign in_fire  = bus.d_valid && !skid_v[0];
        assign out_fire = main_v[depth-1] && bus.q_ready;

        // Occupancy tracks handshakes rather than summing flags every cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count <= '0;
            end else if (clear) begin
                count <= '0;
            end else if (in_fire && !out_fire) begin
                count <= count + count_w'(1);
            end else if (out_fire && !in_fire) begin
                count <= count - count_w'(1);
            end
        end

`ifndef SYNTHESIS
        always @(posedge clk) begin
            if (rst_n) begin
                assert (int'(count) == $countones({main_v, skid_v}));
            end
        end
`endif
`endif
    end

endmodule

// File: doc/hu_pipeline_skid.md
Name: hu_pipeline_skid

Overview:
- Elastic pipeline: `depth` registered stages of type `regtype` with a valid/ready handshake on both ends.
- Each stage is a full-throughput skid buffer, so valid and ready are both registered per stage. No combinational path runs from q_ready to d_ready.
- It is the backpressure-aware complement of the plain free-running pipeline register.
- It sits between a producer and a consumer that can stall, giving timing isolation without throughput loss.

Parameters:
- depth, 1, number of elastic stages; 0 = combinational passthrough (d→q, d_valid→q_valid, q_ready→d_ready, no state).
- regtype, bit[7:0], type of the payload carried per word.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of all stored words.
- d  input  regtype  input payload.
- d_valid  input  1  input word present.
- d_ready  output  1  block can accept; transfer when d_valid && d_ready.
- q  output  regtype  output payload.
- q_valid  output  1  output word present.
- q_ready  input  1  consumer accepts; transfer when q_valid && q_ready.

Behaviour:
- Stage k has a main register (main, main_v) and a skid register (skid, skid_v). Stage input is stage k-1's output; stage 0's input is d. q, q_valid come from the last stage's main, main_v.
- Stage upstream ready = !skid_v (registered). d_ready = stage 0's !skid_v.
- Stage downstream output = main, main_v.
- Per clock, per stage, when (out_ready || !main_v):
  - main <= skid_v ? skid : in
  - main_v <= skid_v || (in_v && !skid_v)
  - skid_v <= 0
- Otherwise (stalled with main full): if in_v && !skid_v, then skid <= in and skid_v <= 1.
- Reset (rst_n low, asynchronous):
  - all main_v = skid_v = 0; all data registers = '0.
  - Hence q_valid = 0, q = '0, d_ready = 1 immediately and while held.
- Latency: word accepted at edge N appears at q_valid after edge N+depth-1, i.e. visible `depth` cycles after acceptance, when no stall.
- Throughput: 1 word/cycle sustained with q_ready held high.
- Capacity: 2*depth words. When all skid registers are full, d_ready = 0.
- Ordering: strict FIFO order; no word dropped or duplicated under any q_ready pattern.
- A stalled stage holds main stable; q and q_valid do not change while q_valid && !q_ready.
- Simultaneous accept and emit at full occupancy: d_ready is already 0, so there is no accept that cycle. d_ready returns to 1 on the edge after the skid drains.
- clear:
  - Takes priority over all transfers: at the edge all valid flags go to 0; data registers hold.
  - An input accepted in the clear cycle is discarded.
  - An output handshake in the clear cycle still counts as delivered to the consumer.
  - After the edge: q_valid = 0, d_ready = 1.
- rst_n deasserted mid-stream: all in-flight words lost. The producer must treat d_ready = 1 after reset as empty.

Optional Feature:
- Macro HU_PIPELINE_SKID_COUNT_EN.
- When defined, an extra output `count` is added, width $clog2(2*depth+1), depth ≥ 1.
- count is a registered occupancy equal to the number of set main_v + skid_v flags.
  - Update per edge: +1 on input transfer, −1 on output transfer, unchanged when both or neither occur.
  - Forced to 0 by rst_n or clear.
- count is checked against the flag population by an assertion in simulation.
- When not defined, the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset: rst_n low with d_valid = 1 → q_valid = 0, q = 0, d_ready = 1; after release, first accepted word 0x11 appears on q with q_valid `depth` cycles later (depth = 3 → 3 cycles).
- Streaming: depth = 2, q_ready = 1, feed 0x00..0x0F back-to-back → q emits 0x00..0x0F on 16 consecutive cycles, d_ready never drops.
- Full backpressure: depth = 2, q_ready = 0, d_valid = 1 with words 1,2,3,4,5 → exactly 4 accepted, d_ready = 0 after 4th; count = 4 if enabled. Release q_ready → 1,2,3,4 out in order, then 5 accepted.
- Random stall: random d_valid / q_ready (50%), 10k words, depth ∈ {0,1,4} → scoreboard exact order match; q stable while q_valid && !q_ready.
- Clear: depth = 2 holding 3 words, clear = 1 for one cycle with d_valid = 1 (0xAA) → next cycle q_valid = 0, d_ready = 1, count = 0; 0xAA never emitted.
- Async reset mid-stream: drop rst_n between edges with 2 words stored → q_valid falls without a clock edge; no stale word appears after release.
